// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port among NUM_REQ load/store requesters.
//   A requester is picked in IDLE. Its request is latched and driven to dmem
//   until dmem_resp. The response is then routed back as a one-cycle pulse.
//
//   state | meaning
//   IDLE  | port free; arbitrate among eligible requesters
//   ISSUE | latched access on dmem; waiting for dmem_resp
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   flush             drop the response of the in-flight access; block grants in IDLE
//   req_addr/rmask/wmask/wdata/urgent   per-requester request (packed, requester i at slice i)
//   req_resp          one-cycle completion pulse to the granted requester
//   req_rdata         load data, valid with req_resp, 0 otherwise
//   dmem_addr/rmask/wmask/wdata         registered request to memory
//   dmem_rdata, dmem_resp               memory read data and completion
//   busy              access in flight
//   grant_idx         index of the requester owning the port (stale in IDLE)
module dmem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*4-1:0]   req_rmask,
  input  logic [NUM_REQ*4-1:0]   req_wmask,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]     req_urgent,
  output logic [NUM_REQ-1:0]     req_resp,
  output logic [31:0]            req_rdata,
  output logic [31:0]            dmem_addr,
  output logic [3:0]             dmem_rmask,
  output logic [3:0]             dmem_wmask,
  output logic [31:0]            dmem_wdata,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_resp,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_idx
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   last_idx;
  logic               last_valid;
  logic               drop;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_sel;
  logic [IDX_W:0]     rr_cand;
  logic [IDX_W:0]     rr_next;
  logic [31:0]        sel_addr;
  logic [3:0]         sel_rmask;
  logic [3:0]         sel_wmask;
  logic [31:0]        sel_wdata;
  logic               resp_fire;

  // The requester served last is held off for one IDLE cycle, so a
  // requester that keeps its mask up after resp is not regranted at once.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = ((|req_rmask[i*4 +: 4]) || (|req_wmask[i*4 +: 4])) && !flush &&
                    !(last_valid && (last_idx == IDX_W'(i)));
    end
  end

  // Urgent requesters win, lowest index first. Otherwise round-robin from
  // rr_ptr. Both loops run downward, so the last hit is the preferred one.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = '0;
    rr_cand     = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (eligible[i] && req_urgent[i]) begin
        grant_valid = 1'b1;
        grant_sel   = IDX_W'(i);
      end
    end
    if (!grant_valid) begin
      for (int k = NUM_REQ-1; k >= 0; k--) begin
        rr_cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (rr_cand >= (IDX_W+1)'(NUM_REQ))
          rr_cand = rr_cand - (IDX_W+1)'(NUM_REQ);
        if (eligible[rr_cand[IDX_W-1:0]]) begin
          grant_valid = 1'b1;
          grant_sel   = rr_cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    rr_next = {1'b0, grant_sel} + (IDX_W+1)'(1);
    if (rr_next >= (IDX_W+1)'(NUM_REQ))
      rr_next = '0;
  end

  always_comb begin
    sel_addr  = '0;
    sel_rmask = '0;
    sel_wmask = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_sel == IDX_W'(i)) begin
        sel_addr  = req_addr[i*32 +: 32];
        sel_rmask = req_rmask[i*4 +: 4];
        sel_wmask = req_wmask[i*4 +: 4];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
    // A load and store together is illegal. The load wins.
    if (sel_rmask != 4'b0)
      sel_wmask = 4'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
      grant_idx  <= '0;
      rr_ptr     <= '0;
      last_idx   <= '0;
      last_valid <= 1'b0;
      drop       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          last_valid <= 1'b0;
          if (grant_valid) begin
            state      <= ISSUE;
            dmem_addr  <= sel_addr;
            dmem_rmask <= sel_rmask;
            dmem_wmask <= sel_wmask;
            dmem_wdata <= sel_wdata;
            grant_idx  <= grant_sel;
            rr_ptr     <= rr_next[IDX_W-1:0];
          end
        end
        ISSUE: begin
          // Memory cannot abort. A flush only suppresses the response.
          if (flush)
            drop <= 1'b1;
          if (dmem_resp) begin
            state      <= IDLE;
            dmem_addr  <= '0;
            dmem_rmask <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            last_idx   <= grant_idx;
            last_valid <= 1'b1;
            drop       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == ISSUE);
  assign resp_fire = busy && dmem_resp && !drop && !flush;

  always_comb begin
    req_resp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (resp_fire && (grant_idx == IDX_W'(i)))
        req_resp[i] = 1'b1;
    end
    req_rdata = resp_fire ? dmem_rdata : 32'h0;
  end

endmodule
